// File: rtl/sync_fifo_rd_stream.sv
// Read-side drain for synchronous_fifo: issues r_en, absorbs the 1-cycle read latency in a
// 2-entry buffer and re-presents words on a valid/ready stream. Optional m_last: SYNC_FIFO_RD_STREAM_LAST_EN.
module sync_fifo_rd_stream #(
    parameter int unsigned DATA_WIDTH = 8
`ifdef SYNC_FIFO_RD_STREAM_LAST_EN
    ,
    parameter int unsigned PKT_LEN    = 4
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  r_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  busy
`ifdef SYNC_FIFO_RD_STREAM_LAST_EN
    ,
    output logic                  m_last
`endif
);

    localparam int unsigned CNT_W = 2;
    localparam int unsigned OCC_W = 3;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic                  pop;
    logic [OCC_W-1:0]      occ_after;
    logic [CNT_W-1:0]      tail;

    assign m_valid = (cnt_q != '0);
    assign m_data  = buf0_q;
    assign busy    = m_valid | inflight_q;
    assign pop     = m_valid & m_ready;

    // Slots committed after this edge, counting the word already in flight
    assign occ_after = OCC_W'(cnt_q) + OCC_W'(inflight_q) - OCC_W'(pop);
    assign r_en      = rst_n & ~fifo_empty & (occ_after < OCC_W'(2));
    assign tail      = cnt_q - CNT_W'(pop);

    // Buffer next-state: pop shifts the head, then the in-flight word lands at the new tail
    always_comb begin
        cnt_d      = cnt_q - CNT_W'(pop) + CNT_W'(inflight_q);
        inflight_d = r_en;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        if (pop) begin
            buf0_d = buf1_q;
        end
        if (inflight_q) begin
            if (tail == '0) begin
                buf0_d = fifo_rdata;
            end else begin
                buf1_d = fifo_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end

`ifdef SYNC_FIFO_RD_STREAM_LAST_EN
    localparam int unsigned BEAT_W = 8;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

    logic [BEAT_W-1:0] beat_q, beat_d;

    assign m_last = m_valid & (beat_q == LAST_BEAT);

    // Beat counter advances on each pop and wraps on the packet's final beat
    always_comb begin
        beat_d = beat_q;
        if (pop) begin
            beat_d = m_last ? '0 : beat_q + BEAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_rd_stream.sv
// Randomized bench for sync_fifo_rd_stream against a queue-based FIFO + stream model.
module tb_sync_fifo_rd_stream;

    localparam int unsigned DW  = 8;
    localparam int unsigned PKT = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rdata;
    logic          r_en;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          busy;
`ifdef SYNC_FIFO_RD_STREAM_LAST_EN
    logic          m_last;
`endif

    sync_fifo_rd_stream #(
        .DATA_WIDTH(DW)
`ifdef SYNC_FIFO_RD_STREAM_LAST_EN
        ,
        .PKT_LEN(PKT)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata),
        .r_en      (r_en),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .busy      (busy)
`ifdef SYNC_FIFO_RD_STREAM_LAST_EN
        ,
        .m_last    (m_last)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [DW-1:0] fq[$];   // FIFO contents
    logic [DW-1:0] sb[$];   // words the consumer must see, in order
    logic [DW-1:0] mb[$];   // reference: words visible to the consumer side
    logic          infl;
    logic [DW-1:0] infl_w;
    int unsigned   beats;
    logic          in_rst;
    logic          chk_en;
    int unsigned   issued;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        fq.push_back(w);
        sb.push_back(w);
    endtask

    // One clock: drive inputs, compare against the model, then advance FIFO and model at the edge
    task automatic step(input logic rdy);
        logic          exp_ren, exp_valid, exp_busy, pop_m, acc;
        logic [DW-1:0] pk;
        int            occ;
        m_ready    = rdy;
        fifo_empty = (fq.size() == 0);
        #1;
        pop_m     = (mb.size() != 0) && rdy;
        occ       = mb.size() + (infl ? 1 : 0) - (pop_m ? 1 : 0);
        exp_ren   = rst_n && !fifo_empty && (occ < 2);
        exp_valid = (mb.size() != 0);
        exp_busy  = exp_valid || infl;
        if (chk_en) begin
            check("r_en", 32'(r_en), 32'(exp_ren));
            check("m_valid", 32'(m_valid), 32'(exp_valid));
            check("busy", 32'(busy), 32'(exp_busy));
            if (exp_valid) check("m_data", 32'(m_data), 32'(mb[0]));
            else if (in_rst) check("m_data_rst", 32'(m_data), 32'd0);
`ifdef SYNC_FIFO_RD_STREAM_LAST_EN
            check("m_last", 32'(m_last),
                  32'(exp_valid && ((beats % PKT) == PKT - 1)));
`endif
            if (rst_n && m_valid === 1'b1 && m_ready) begin
                if (sb.size() == 0) check("sb_extra", 32'd1, 32'd0);
                else check("sb_order", 32'(m_data), 32'(sb.pop_front()));
            end
        end
        acc = (r_en === 1'b1) && !fifo_empty;
        pk  = (fq.size() != 0) ? fq[0] : '0;
        @(posedge clk);
        if (!rst_n) begin
            fifo_rdata <= '0;
            mb.delete();
            infl   = 1'b0;
            beats  = 0;
            in_rst = 1'b1;
        end else begin
            if (acc) begin
                fifo_rdata <= fq.pop_front();
                issued++;
            end
            if (pop_m) begin
                void'(mb.pop_front());
                beats++;
            end
            if (infl) mb.push_back(infl_w);
            infl   = exp_ren;
            infl_w = pk;
            in_rst = 1'b0;
        end
        chk_en = 1'b1;
        @(negedge clk);
    endtask

    // Drain until FIFO and stream are empty; mode 0 ready, 1 alternating, 2 random
    task automatic drain(input int mode);
        int  k;
        logic idle;
        k = 0;
        idle = 1'b0;
        while (!idle && k < 400) begin
            case (mode)
                0:       step(1'b1);
                1:       step(k[0] == 1'b0);
                default: step(1'($urandom_range(0, 1)));
            endcase
            k++;
            idle = (fq.size() == 0) && (mb.size() == 0) && !infl;
        end
        check("drain_timeout", 32'(idle), 32'd1);
        check("sb_left", 32'(sb.size()), 32'd0);
    endtask

    task automatic begin_reset();
        rst_n = 1'b0;
        fq.delete();
        sb.delete();
    endtask

    initial begin
        fifo_rdata = '0;
        m_ready    = 1'b0;
        fifo_empty = 1'b1;
        infl       = 1'b0;
        infl_w     = '0;
        beats      = 0;
        in_rst     = 1'b0;
        chk_en     = 1'b0;
        issued     = 0;

        // Reset held with a non-empty FIFO, then the 4-word stream
        begin_reset();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        repeat (10) step(1'b1);
        rst_n = 1'b1;
        drain(0);
        check("idle_busy", 32'(busy), 32'd0);

        // Backpressure: only two reads may issue while stalled
        for (int i = 0; i < 5; i++) push(8'($urandom));
        issued = 0;
        repeat (6) step(1'b0);
        check("bp_issued", issued, 32'd2);
        step(1'b1);
        check("bp_refill", issued, 32'd3);
        repeat (3) step(1'b0);
        drain(0);

        // Alternating ready over 30 random words
        for (int i = 0; i < 30; i++) push(8'($urandom));
        drain(1);

        // Random ready with words trickling in mid-stream
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 2) == 0) push(8'($urandom));
            step(1'($urandom_range(0, 1)));
        end
        drain(2);

        // Reset with words buffered and one in flight
        for (int i = 0; i < 5; i++) push(8'($urandom));
        step(1'b0);
        step(1'b0);
        check("pre_rst_busy", 32'(busy), 32'd1);
        begin_reset();
        step(1'b0);
        check("rst_mid_valid", 32'(m_valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        push(8'hA5);
        step(1'b0);
        rst_n = 1'b1;
        drain(0);

        // Seven words through the packet framing (PKT=3 when enabled)
        begin_reset();
        step(1'b1);
        rst_n = 1'b1;
        for (int i = 1; i <= 7; i++) push(8'(i));
        drain(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
